// File: rtl/mul4_share_arb_if.sv
// Requester and response channels of the shared 4x4 multiplier.
// The master side drives operands and resp_ready; the slave side is the arbiter.
interface mul4_share_arb_if #(
    parameter int NREQ = 2,
    parameter int IDW  = 1
);
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [4*NREQ-1:0] req_a;
    logic [4*NREQ-1:0] req_b;
    logic              resp_valid;
    logic              resp_ready;
    logic [7:0]        resp_p;
    logic [IDW-1:0]    resp_id;
    logic              busy;

    modport master (
        output req_valid, req_a, req_b, resp_ready,
        input  req_ready, resp_valid, resp_p, resp_id, busy
    );

    modport slave (
        input  req_valid, req_a, req_b, resp_ready,
        output req_ready, resp_valid, resp_p, resp_id, busy
    );
endinterface

// File: rtl/mul4_share_arb.sv
// Round-robin arbiter sharing one combinational 4x4 array multiplier among NREQ requesters.
// The product comes back registered and tagged with the owner id, with backpressure.
module mul4_share_arb #(
    parameter int NREQ = 2,
    parameter int IDW  = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    mul4_share_arb_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0] id_q, id_d;
    logic [IDW-1:0] resp_id_q, resp_id_d;
    logic [3:0]     a_q, a_d;
    logic [3:0]     b_q, b_d;
    logic [7:0]     resp_p_q, resp_p_d;
    logic           resp_valid_q, resp_valid_d;

    logic           grant_found;
    logic [IDW-1:0] grant_idx;
    logic [IDW-1:0] scan;
    logic [7:0]     mul_p;

    // Array multiplier: shifted partial products accumulated row by row.
    logic [7:0] pp  [4];
    logic [7:0] acc [5];
    assign acc[0] = 8'd0;
    for (genvar gi = 0; gi < 4; gi++) begin : g_row
        assign pp[gi]      = b_q[gi] ? ({4'd0, a_q} << gi) : 8'd0;
        assign acc[gi + 1] = acc[gi] + pp[gi];
    end
    assign mul_p = acc[4];

    // First valid requester at or after rr_ptr, wrapping modulo NREQ.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        scan        = rr_ptr_q;
        for (int k = 0; k < NREQ; k++) begin
            if (!grant_found && bus.req_valid[scan]) begin
                grant_found = 1'b1;
                grant_idx   = scan;
            end
            scan = (scan == IDW'(NREQ - 1)) ? '0 : scan + IDW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            rr_ptr_q     <= '0;
            id_q         <= '0;
            a_q          <= 4'd0;
            b_q          <= 4'd0;
            resp_p_q     <= 8'd0;
            resp_id_q    <= '0;
            resp_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            id_q         <= id_d;
            a_q          <= a_d;
            b_q          <= b_d;
            resp_p_q     <= resp_p_d;
            resp_id_q    <= resp_id_d;
            resp_valid_q <= resp_valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (grant_found) state_d = CALC;
            CALC:    state_d = RESP;
            RESP:    if (bus.resp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rr_ptr_d     = rr_ptr_q;
        id_d         = id_q;
        a_d          = a_q;
        b_d          = b_q;
        resp_p_d     = resp_p_q;
        resp_id_d    = resp_id_q;
        resp_valid_d = resp_valid_q;
        case (state_q)
            IDLE: begin
                resp_valid_d = 1'b0;
                if (grant_found) begin
                    a_d      = bus.req_a[{grant_idx, 2'b00} +: 4];
                    b_d      = bus.req_b[{grant_idx, 2'b00} +: 4];
                    id_d     = grant_idx;
                    rr_ptr_d = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + IDW'(1);
                end
            end
            CALC: begin
                resp_p_d     = mul_p;
                resp_id_d    = id_q;
                resp_valid_d = 1'b1;
            end
            RESP: begin
                if (bus.resp_ready) resp_valid_d = 1'b0;
            end
            default: resp_valid_d = 1'b0;
        endcase
    end

    // The accept strobe is combinational, so it is also masked while reset is held.
    always_comb begin
        bus.req_ready = '0;
        if (rst_n && (state_q == IDLE) && grant_found) begin
            bus.req_ready = NREQ'(1) << grant_idx;
        end
        bus.busy       = (state_q != IDLE);
        bus.resp_valid = resp_valid_q;
        bus.resp_p     = resp_p_q;
        bus.resp_id    = resp_id_q;
    end
endmodule

// File: tb/tb_mul4_share_arb.sv
// Bench for mul4_share_arb: a cycle model pushes expected products into a queue on each
// grant, and a separate monitor pops and compares them at every response handshake.
module tb_mul4_share_arb;
    logic clk = 1'b0;
    logic rst_n;
    bit   started = 1'b0;
    int   n_err = 0;
    int   n_checks = 0;
    int   n_resp = 0;

    always #5 clk = ~clk;

    mul4_share_arb_if #(.NREQ(2), .IDW(1)) intf ();
    mul4_share_arb #(.NREQ(2), .IDW(1)) dut (.clk(clk), .rst_n(rst_n), .bus(intf));

    typedef struct packed {
        logic [0:0] id;
        logic [7:0] p;
    } exp_t;
    exp_t exp_q[$];

    localparam int M_IDLE = 0, M_CALC = 1, M_RESP = 2;
    int         m_state = M_IDLE;
    logic [0:0] m_ptr = 1'b0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endfunction

    // Cycle model: checks handshake outputs and predicts the grant for the next edge.
    always @(negedge clk) begin : model
        logic [1:0] exp_rdy;
        logic [0:0] idx;
        logic [0:0] g;
        logic [3:0] ga, gb;
        bit         found;
        if (started) begin
            exp_rdy = 2'b00;
            found   = 1'b0;
            g       = 1'b0;
            if (rst_n && m_state == M_IDLE) begin
                for (int k = 0; k < 2; k++) begin
                    idx = m_ptr ^ 1'(k);
                    if (!found && intf.req_valid[idx]) begin
                        found = 1'b1;
                        g     = idx;
                    end
                end
                if (found) exp_rdy = 2'b01 << g;
            end
            chk("req_ready", 32'(intf.req_ready), 32'(exp_rdy));
            chk("busy", 32'(intf.busy), 32'(m_state != M_IDLE));
            chk("resp_valid_state", 32'(intf.resp_valid), 32'(m_state == M_RESP));
            if (!rst_n) begin
                m_state = M_IDLE;
                m_ptr   = 1'b0;
                exp_q.delete();
            end else begin
                case (m_state)
                    M_IDLE: if (found) begin
                        ga = intf.req_a[{g, 2'b00} +: 4];
                        gb = intf.req_b[{g, 2'b00} +: 4];
                        exp_q.push_back('{id: g, p: {4'd0, ga} * {4'd0, gb}});
                        m_ptr   = ~g;
                        m_state = M_CALC;
                    end
                    M_CALC:  m_state = M_RESP;
                    default: if (intf.resp_ready) m_state = M_IDLE;
                endcase
            end
        end
    end

    // Monitor: compares the presented response against the queue head every cycle.
    always @(negedge clk) begin
        if (started && rst_n && intf.resp_valid) begin
            if (exp_q.size() == 0) begin
                chk("resp_unexpected", 32'(intf.resp_valid), 32'd0);
            end else begin
                chk("resp_p", 32'(intf.resp_p), 32'(exp_q[0].p));
                chk("resp_id", 32'(intf.resp_id), 32'(exp_q[0].id));
                if (intf.resp_ready) begin
                    $display("resp id=%0d p=%02h", intf.resp_id, intf.resp_p);
                    void'(exp_q.pop_front());
                    n_resp++;
                end
            end
        end
    end

    task automatic wait_accept(input int i, input bit rnd, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (intf.req_ready[i[0]]) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
            if (rnd) intf.resp_ready = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic wait_resp(output logic [7:0] p, output logic [0:0] id, output int cnt, output bit ok);
        ok = 1'b0; p = 8'd0; id = 1'b0; cnt = 0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            cnt++;
            if (intf.resp_valid && intf.resp_ready) begin
                ok = 1'b1; p = intf.resp_p; id = intf.resp_id;
                break;
            end
        end
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        bit         ok;
        logic [7:0] p;
        logic [0:0] id;
        int         cnt, base;
        rst_n = 1'b0;
        intf.req_valid = 2'b00; intf.req_a = 8'h00; intf.req_b = 8'h00;
        intf.resp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 started = 1'b1;

        // 1: reset held with every requester valid
        intf.req_valid = 2'b11; intf.req_a = 8'h53; intf.req_b = 8'h97;
        repeat (3) begin
            @(negedge clk);
            chk("rst_req_ready", 32'(intf.req_ready), 32'd0);
            chk("rst_resp_valid", 32'(intf.resp_valid), 32'd0);
            chk("rst_resp_p", 32'(intf.resp_p), 32'd0);
            chk("rst_busy", 32'(intf.busy), 32'd0);
        end

        // 2: single request 15*15
        @(posedge clk); #1;
        rst_n = 1'b1; intf.resp_ready = 1'b1;
        intf.req_a = 8'h0F; intf.req_b = 8'h0F; intf.req_valid = 2'b01;
        wait_accept(0, 1'b0, ok);
        chk("t2_accept", 32'(ok), 32'd1);
        @(posedge clk); #1 intf.req_valid = 2'b00;
        wait_resp(p, id, cnt, ok);
        chk("t2_resp", 32'(ok), 32'd1);
        chk("t2_p", 32'(p), 32'hE1);
        chk("t2_id", 32'(id), 32'd0);
        chk("t2_latency", 32'(cnt), 32'd2);

        // 3: contention from reset, 3*5 and 7*9 alternate
        @(posedge clk); #1;
        rst_n = 1'b0; intf.req_valid = 2'b11; intf.req_a = 8'h73; intf.req_b = 8'h95;
        @(posedge clk); #1 rst_n = 1'b1;
        for (int r = 0; r < 4; r++) begin
            wait_resp(p, id, cnt, ok);
            chk("t3_resp", 32'(ok), 32'd1);
            chk("t3_p", 32'(p), (r % 2 == 0) ? 32'h0F : 32'h3F);
            chk("t3_id", 32'(id), 32'(r % 2));
        end

        // 4: backpressure on 12*11 = 0x84
        @(posedge clk); #1 intf.req_valid = 2'b00;
        repeat (5) @(posedge clk);
        #1;
        intf.req_a = 8'h0C; intf.req_b = 8'h0B; intf.req_valid = 2'b01; intf.resp_ready = 1'b0;
        wait_accept(0, 1'b0, ok);
        chk("t4_accept", 32'(ok), 32'd1);
        @(posedge clk); #1 intf.req_valid = 2'b00;
        repeat (2) @(posedge clk);
        #1 intf.req_valid = 2'b11;
        repeat (10) begin
            @(negedge clk);
            chk("t4_stall_valid", 32'(intf.resp_valid), 32'd1);
            chk("t4_stall_p", 32'(intf.resp_p), 32'h84);
            chk("t4_stall_id", 32'(intf.resp_id), 32'd0);
            chk("t4_stall_ready", 32'(intf.req_ready), 32'd0);
            chk("t4_stall_busy", 32'(intf.busy), 32'd1);
        end
        @(posedge clk); #1 intf.resp_ready = 1'b1; intf.req_valid = 2'b00;
        @(negedge clk);
        chk("t4_handshake", 32'(intf.resp_valid), 32'd1);
        @(negedge clk);
        chk("t4_idle_valid", 32'(intf.resp_valid), 32'd0);
        chk("t4_idle_busy", 32'(intf.busy), 32'd0);

        // 5: reset during CALC discards the transaction
        @(posedge clk); #1;
        intf.req_a = 8'h73; intf.req_b = 8'h95; intf.req_valid = 2'b10;
        wait_accept(1, 1'b0, ok);
        chk("t5_accept", 32'(ok), 32'd1);
        @(posedge clk); #1 rst_n = 1'b0; intf.req_valid = 2'b11;
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        chk("t5_grant_req0", 32'(intf.req_ready), 32'd1);
        chk("t5_no_resp", 32'(intf.resp_valid), 32'd0);
        @(posedge clk); #1 intf.req_valid = 2'b00;
        wait_resp(p, id, cnt, ok);
        chk("t5_p", 32'(p), 32'h0F);
        chk("t5_id", 32'(id), 32'd0);

        // 6: all 256 operand pairs, random requester and random stalls
        @(posedge clk); #1;
        base = n_resp;
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                int i;
                i = $urandom_range(0, 1);
                if (a != 0 || b != 0) begin
                    @(posedge clk); #1;
                end
                intf.req_a = 8'h00; intf.req_b = 8'h00;
                intf.req_a[4*i +: 4] = 4'(a);
                intf.req_b[4*i +: 4] = 4'(b);
                intf.req_valid = 2'b01 << i;
                intf.resp_ready = 1'($urandom_range(0, 1));
                wait_accept(i, 1'b1, ok);
                if (!ok) chk("t6_accept", 32'(ok), 32'd1);
            end
        end
        @(posedge clk); #1 intf.req_valid = 2'b00; intf.resp_ready = 1'b1;
        for (int c = 0; c < 20 && exp_q.size() != 0; c++) @(negedge clk);
        @(negedge clk);
        chk("t6_count", 32'(n_resp - base), 32'd256);
        chk("t6_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
